// File: rtl/ysyx_24080014_pkg.sv
// Shared types and constants for the ysyx_24080014 instruction fetch unit:
// FSM state encoding, fault codes, AXI response code and the reset PC.
package ysyx_24080014_pkg;

  typedef enum logic [1:0] {
    ST_AR  = 2'd0,
    ST_R   = 2'd1,
    ST_OUT = 2'd2,
    ST_NPC = 2'd3
  } ifu_state_e;

  localparam logic [1:0]  IFU_FAULT_NONE     = 2'd0;
  localparam logic [1:0]  IFU_FAULT_ACCESS   = 2'd1;
  localparam logic [1:0]  IFU_FAULT_MISALIGN = 2'd2;

  localparam logic [1:0]  RESP_OKAY    = 2'b00;
  localparam logic [31:0] IFU_RESET_PC = 32'h8000_0000;

  function automatic logic is_misaligned(input logic [1:0] low_bits);
    return low_bits != 2'b00;
  endfunction

endpackage

// File: rtl/ysyx_24080014_ifu_perf.sv
// Fetch performance counters: completed fetches and cycles spent waiting on
// the read bus. Only instantiated when YSYX_24080014_IFU_PERF_EN is defined.
module ysyx_24080014_ifu_perf (
  input  logic        clk,
  input  logic        rst,
  input  logic        i_fire,
  input  logic        i_stall,
  output logic [63:0] o_fetch_cnt,
  output logic [63:0] o_fetch_stall_cnt
);

  logic [63:0] r_fetch_cnt;
  logic [63:0] r_fetch_stall_cnt;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_fetch_cnt       <= '0;
      r_fetch_stall_cnt <= '0;
    end else begin
      if (i_fire)  r_fetch_cnt       <= r_fetch_cnt + 64'd1;
      if (i_stall) r_fetch_stall_cnt <= r_fetch_stall_cnt + 64'd1;
    end
  end

  assign o_fetch_cnt       = r_fetch_cnt;
  assign o_fetch_stall_cnt = r_fetch_stall_cnt;

endmodule

// File: rtl/ysyx_24080014_ifu.sv
// Multi-cycle, non-pipelined instruction fetch unit (AR -> R -> OUT -> NPC).
// Optional counters enabled by defining YSYX_24080014_IFU_PERF_EN.
module ysyx_24080014_ifu
  import ysyx_24080014_pkg::*;
#(
  parameter int                XLEN     = 32,
  parameter logic [XLEN-1:0]   RESET_PC = IFU_RESET_PC
) (
  input  logic            clk,
  input  logic            rst,
  output logic [XLEN-1:0] araddr,
  output logic            arvalid,
  input  logic            arready,
  input  logic [XLEN-1:0] rdata,
  input  logic [1:0]      rresp,
  input  logic            rvalid,
  output logic            rready,
  output logic [XLEN-1:0] inst,
  output logic [XLEN-1:0] inst_pc,
  output logic [1:0]      inst_fault,
  output logic            inst_valid,
  input  logic            inst_ready,
  input  logic            npc_valid,
  input  logic [XLEN-1:0] next_pc,
  output logic            npc_ready
`ifdef YSYX_24080014_IFU_PERF_EN
  ,
  output logic [63:0]     fetch_cnt,
  output logic [63:0]     fetch_stall_cnt
`endif
);

  ifu_state_e      r_state;
  logic [XLEN-1:0] r_pc;
  logic [XLEN-1:0] r_inst;
  logic [XLEN-1:0] r_inst_pc;
  logic [1:0]      r_inst_fault;
  logic            r_arvalid;
  logic            r_rready;
  logic            r_inst_valid;
  logic            r_npc_ready;

  logic            w_take_npc;
  logic            w_npc_misalign;

  // In OUT the next PC may only be taken together with the instruction handoff.
  assign w_take_npc     = npc_valid &&
                          (((r_state == ST_OUT) && inst_ready) || (r_state == ST_NPC));
  assign w_npc_misalign = is_misaligned(next_pc[1:0]);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state      <= ST_AR;
      r_pc         <= RESET_PC;
      r_inst       <= '0;
      r_inst_pc    <= '0;
      r_inst_fault <= IFU_FAULT_NONE;
      r_arvalid    <= 1'b0;
      r_rready     <= 1'b0;
      r_inst_valid <= 1'b0;
      r_npc_ready  <= 1'b0;
    end else begin
      unique case (r_state)
        ST_AR: begin
          if (r_arvalid && arready) begin
            r_state   <= ST_R;
            r_arvalid <= 1'b0;
            r_rready  <= 1'b1;
          end else begin
            r_arvalid <= 1'b1;
          end
        end
        ST_R: begin
          if (rvalid) begin
            r_state      <= ST_OUT;
            r_rready     <= 1'b0;
            r_inst_valid <= 1'b1;
            r_npc_ready  <= 1'b1;
            r_inst_pc    <= r_pc;
            if (rresp != RESP_OKAY) begin
              r_inst       <= '0;
              r_inst_fault <= IFU_FAULT_ACCESS;
            end else begin
              r_inst       <= rdata;
              r_inst_fault <= IFU_FAULT_NONE;
            end
          end
        end
        ST_OUT: begin
          if (inst_ready) begin
            r_state      <= ST_NPC;
            r_inst_valid <= 1'b0;
          end
        end
        ST_NPC: begin
        end
      endcase

      // A misaligned target never reaches the bus; it is reported straight to decode.
      if (w_take_npc) begin
        r_pc <= next_pc;
        if (w_npc_misalign) begin
          r_state      <= ST_OUT;
          r_inst       <= '0;
          r_inst_pc    <= next_pc;
          r_inst_fault <= IFU_FAULT_MISALIGN;
          r_inst_valid <= 1'b1;
          r_npc_ready  <= 1'b1;
        end else begin
          r_state      <= ST_AR;
          r_arvalid    <= 1'b1;
          r_inst_valid <= 1'b0;
          r_npc_ready  <= 1'b0;
        end
      end
    end
  end

  assign araddr     = r_pc;
  assign arvalid    = r_arvalid;
  assign rready     = r_rready;
  assign inst       = r_inst;
  assign inst_pc    = r_inst_pc;
  assign inst_fault = r_inst_fault;
  assign inst_valid = r_inst_valid;
  assign npc_ready  = r_npc_ready;

`ifdef YSYX_24080014_IFU_PERF_EN
  logic w_fire;
  logic w_stall;

  assign w_fire  = r_inst_valid && inst_ready;
  assign w_stall = (r_state == ST_AR) || (r_state == ST_R);

  ysyx_24080014_ifu_perf u_perf (
    .clk               (clk),
    .rst               (rst),
    .i_fire            (w_fire),
    .i_stall           (w_stall),
    .o_fetch_cnt       (fetch_cnt),
    .o_fetch_stall_cnt (fetch_stall_cnt)
  );
`endif

endmodule

// File: tb/tb_ysyx_24080014_ifu.sv
// Directed self-checking bench for ysyx_24080014_ifu; inputs are driven and
// outputs sampled on the falling clock edge.
module tb_ysyx_24080014_ifu;

  logic        clk;
  logic        rst;
  logic [31:0] araddr;
  logic        arvalid;
  logic        arready;
  logic [31:0] rdata;
  logic [1:0]  rresp;
  logic        rvalid;
  logic        rready;
  logic [31:0] inst;
  logic [31:0] inst_pc;
  logic [1:0]  inst_fault;
  logic        inst_valid;
  logic        inst_ready;
  logic        npc_valid;
  logic [31:0] next_pc;
  logic        npc_ready;
`ifdef YSYX_24080014_IFU_PERF_EN
  logic [63:0] fetch_cnt;
  logic [63:0] fetch_stall_cnt;
`endif

  int checks;
  int errors;
  int hs_cnt;

  ysyx_24080014_ifu dut (
    .clk        (clk),
    .rst        (rst),
    .araddr     (araddr),
    .arvalid    (arvalid),
    .arready    (arready),
    .rdata      (rdata),
    .rresp      (rresp),
    .rvalid     (rvalid),
    .rready     (rready),
    .inst       (inst),
    .inst_pc    (inst_pc),
    .inst_fault (inst_fault),
    .inst_valid (inst_valid),
    .inst_ready (inst_ready),
    .npc_valid  (npc_valid),
    .next_pc    (next_pc),
    .npc_ready  (npc_ready)
`ifdef YSYX_24080014_IFU_PERF_EN
    ,
    .fetch_cnt       (fetch_cnt),
    .fetch_stall_cnt (fetch_stall_cnt)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) begin
    if (arvalid && arready) hs_cnt <= hs_cnt + 1;
  end

  task automatic test_reset();
    rst = 1'b0;
    arready = 0; rvalid = 0; rdata = 0; rresp = 0;
    inst_ready = 0; npc_valid = 0; next_pc = 0;
    repeat (3) @(negedge clk);
    checks++;
    if (arvalid !== 1'b0 || rready !== 1'b0 || inst_valid !== 1'b0 || npc_ready !== 1'b0) begin
      errors++;
      $display("[TB] FAIL reset_handshakes got arv=%b rr=%b iv=%b nr=%b want all 0",
               arvalid, rready, inst_valid, npc_ready);
    end
    checks++;
    if (inst !== 32'h0 || inst_pc !== 32'h0 || inst_fault !== 2'd0 || araddr !== 32'h8000_0000) begin
      errors++;
      $display("[TB] FAIL reset_payload got inst=%h pc=%h f=%0d araddr=%h want 0/0/0/80000000",
               inst, inst_pc, inst_fault, araddr);
    end
    rst = 1'b1;
  endtask

  // Runs from the cycle reset is released; zero-wait bus returns 32'h00000413.
  task automatic test_zero_wait();
    arready = 1; rvalid = 1; rdata = 32'h0000_0413; rresp = 2'b00;
    @(negedge clk);
    checks++;
    if (arvalid !== 1'b1 || araddr !== 32'h8000_0000) begin
      errors++;
      $display("[TB] FAIL zw_cycle1 got arv=%b araddr=%h want 1/80000000", arvalid, araddr);
    end
    @(negedge clk);
    checks++;
    if (rready !== 1'b1 || arvalid !== 1'b0 || inst_valid !== 1'b0) begin
      errors++;
      $display("[TB] FAIL zw_cycle2 got rr=%b arv=%b iv=%b want 1/0/0", rready, arvalid, inst_valid);
    end
    @(negedge clk);
    arready = 0; rvalid = 0;
    checks++;
    if (inst_valid !== 1'b1 || inst !== 32'h0000_0413 || inst_pc !== 32'h8000_0000 ||
        inst_fault !== 2'd0 || npc_ready !== 1'b1) begin
      errors++;
      $display("[TB] FAIL zw_cycle3 got iv=%b inst=%h pc=%h f=%0d nr=%b want 1/00000413/80000000/0/1",
               inst_valid, inst, inst_pc, inst_fault, npc_ready);
    end
    inst_ready = 1;
    @(negedge clk);
    inst_ready = 0;
    checks++;
    if (inst_valid !== 1'b0 || npc_ready !== 1'b1 || arvalid !== 1'b0) begin
      errors++;
      $display("[TB] FAIL zw_npc_state got iv=%b nr=%b arv=%b want 0/1/0", inst_valid, npc_ready, arvalid);
    end
    npc_valid = 1; next_pc = 32'h8000_0004;
    @(negedge clk);
    npc_valid = 0;
    checks++;
    if (arvalid !== 1'b1 || araddr !== 32'h8000_0004 || npc_ready !== 1'b0) begin
      errors++;
      $display("[TB] FAIL zw_next_fetch got arv=%b araddr=%h nr=%b want 1/80000004/0",
               arvalid, araddr, npc_ready);
    end
  endtask

  task automatic test_ar_stall();
    int hs_start;
    int stable_bad;
    hs_start = hs_cnt;
    stable_bad = 0;
    arready = 0;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      if (arvalid !== 1'b1 || araddr !== 32'h8000_0004) stable_bad++;
    end
    checks++;
    if (stable_bad != 0) begin
      errors++;
      $display("[TB] FAIL ar_stall_stable got %0d unstable cycles want 0", stable_bad);
    end
    arready = 1;
    @(negedge clk);
    arready = 0;
    checks++;
    if (arvalid !== 1'b0 || rready !== 1'b1) begin
      errors++;
      $display("[TB] FAIL ar_stall_to_r got arv=%b rr=%b want 0/1", arvalid, rready);
    end
    rvalid = 1; rdata = 32'h0010_0093; rresp = 2'b00;
    @(negedge clk);
    rvalid = 0;
    checks++;
    if (hs_cnt - hs_start != 1) begin
      errors++;
      $display("[TB] FAIL ar_stall_handshakes got %0d want 1", hs_cnt - hs_start);
    end
    checks++;
    if (inst_valid !== 1'b1 || inst !== 32'h0010_0093 || inst_pc !== 32'h8000_0004 || inst_fault !== 2'd0) begin
      errors++;
      $display("[TB] FAIL ar_stall_inst got iv=%b inst=%h pc=%h f=%0d want 1/00100093/80000004/0",
               inst_valid, inst, inst_pc, inst_fault);
    end
  endtask

  task automatic test_out_stall();
    int stable_bad;
    stable_bad = 0;
    inst_ready = 0; npc_valid = 0;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      if (inst_valid !== 1'b1 || inst !== 32'h0010_0093 || inst_pc !== 32'h8000_0004) stable_bad++;
    end
    checks++;
    if (stable_bad != 0) begin
      errors++;
      $display("[TB] FAIL out_stall_stable got %0d unstable cycles want 0", stable_bad);
    end
    inst_ready = 1; npc_valid = 1; next_pc = 32'h8000_0010;
    @(negedge clk);
    inst_ready = 0; npc_valid = 0;
    checks++;
    if (arvalid !== 1'b1 || araddr !== 32'h8000_0010 || inst_valid !== 1'b0) begin
      errors++;
      $display("[TB] FAIL out_skip_npc got arv=%b araddr=%h iv=%b want 1/80000010/0",
               arvalid, araddr, inst_valid);
    end
  endtask

  task automatic test_access_fault();
    arready = 1;
    @(negedge clk);
    arready = 0;
    rvalid = 1; rdata = 32'hDEAD_BEEF; rresp = 2'b10;
    @(negedge clk);
    rvalid = 0; rresp = 2'b00;
    checks++;
    if (inst_valid !== 1'b1 || inst !== 32'h0 || inst_fault !== 2'd1 || inst_pc !== 32'h8000_0010) begin
      errors++;
      $display("[TB] FAIL access_fault got iv=%b inst=%h f=%0d pc=%h want 1/00000000/1/80000010",
               inst_valid, inst, inst_fault, inst_pc);
    end
  endtask

  task automatic test_misalign();
    inst_ready = 1; npc_valid = 1; next_pc = 32'h8000_0006;
    @(negedge clk);
    inst_ready = 0; npc_valid = 0;
    checks++;
    if (arvalid !== 1'b0 || inst_valid !== 1'b1 || inst_pc !== 32'h8000_0006 ||
        inst_fault !== 2'd2 || inst !== 32'h0 || araddr !== 32'h8000_0006) begin
      errors++;
      $display("[TB] FAIL misalign got arv=%b iv=%b pc=%h f=%0d inst=%h araddr=%h want 0/1/80000006/2/0/80000006",
               arvalid, inst_valid, inst_pc, inst_fault, inst, araddr);
    end
    @(negedge clk);
    checks++;
    if (arvalid !== 1'b0 || inst_valid !== 1'b1) begin
      errors++;
      $display("[TB] FAIL misalign_hold got arv=%b iv=%b want 0/1", arvalid, inst_valid);
    end
    inst_ready = 1; npc_valid = 1; next_pc = 32'h8000_0020;
    @(negedge clk);
    inst_ready = 0; npc_valid = 0;
    checks++;
    if (arvalid !== 1'b1 || araddr !== 32'h8000_0020) begin
      errors++;
      $display("[TB] FAIL misalign_recover got arv=%b araddr=%h want 1/80000020", arvalid, araddr);
    end
  endtask

  task automatic test_reset_mid();
    arready = 1;
    @(negedge clk);
    arready = 0;
    checks++;
    if (rready !== 1'b1) begin
      errors++;
      $display("[TB] FAIL mid_in_r got rr=%b want 1", rready);
    end
    rst = 1'b0;
    #1;
    checks++;
    if (rready !== 1'b0 || arvalid !== 1'b0 || araddr !== 32'h8000_0000) begin
      errors++;
      $display("[TB] FAIL mid_async_reset got rr=%b arv=%b araddr=%h want 0/0/80000000",
               rready, arvalid, araddr);
    end
    rvalid = 1; rdata = 32'h1234_5678; rresp = 2'b00;
    @(negedge clk);
    checks++;
    if (inst !== 32'h0 || inst_valid !== 1'b0 || rready !== 1'b0) begin
      errors++;
      $display("[TB] FAIL mid_stale_rvalid got inst=%h iv=%b rr=%b want 0/0/0", inst, inst_valid, rready);
    end
    rst = 1'b1; rvalid = 0;
    @(negedge clk);
    checks++;
    if (arvalid !== 1'b1 || araddr !== 32'h8000_0000 || rready !== 1'b0) begin
      errors++;
      $display("[TB] FAIL mid_restart got arv=%b araddr=%h rr=%b want 1/80000000/0", arvalid, araddr, rready);
    end
    arready = 1;
    @(negedge clk);
    arready = 0;
    rvalid = 1; rdata = 32'h0000_0513;
    @(negedge clk);
    rvalid = 0;
    checks++;
    if (inst_valid !== 1'b1 || inst !== 32'h0000_0513 || inst_pc !== 32'h8000_0000 || inst_fault !== 2'd0) begin
      errors++;
      $display("[TB] FAIL mid_refetch got iv=%b inst=%h pc=%h f=%0d want 1/00000513/80000000/0",
               inst_valid, inst, inst_pc, inst_fault);
    end
  endtask

  initial begin
    checks = 0;
    errors = 0;
    hs_cnt = 0;
    test_reset();
    test_zero_wait();
    test_ar_stall();
    test_out_stall();
    test_access_fault();
    test_misalign();
    test_reset_mid();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
